mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4: max consecutive data grants while fetch is pending.
REQ-002 clk  in  1  single clock; all state on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-low.
REQ-004 if_req  in  1  fetch request; held until if_valid.
REQ-005 if_addr  in  32  fetch byte address.
REQ-006 if_rdata  out  32  fetched word.
REQ-007 if_valid  out  1  one-cycle fetch completion pulse.
REQ-008 dm_req  in  1  data request from MEM stage; held until dm_valid.
REQ-009 dm_we  in  1  1 = store, 0 = load.
REQ-010 dm_byte  in  1  byte access (LB/LBU/SB).
REQ-011 dm_signextend  in  1  sign-extend byte loads.
REQ-012 dm_addr  in  32  data byte address.
REQ-013 dm_wdata  in  32  store data; byte stores use bits [7:0].
REQ-014 dm_rdata  out  32  load result, extended for byte loads.
REQ-015 dm_valid  out  1  one-cycle data completion pulse.
REQ-016 dm_misalign  out  1  word access with dm_addr[1:0] != 0; valid only with dm_valid.
REQ-017 mem_req  out  1  shared memory port request.
REQ-018 mem_we  out  1  write enable.
REQ-019 mem_addr  out  32  word address {addr[31:2],2'b00}.
REQ-020 mem_wdata  out  32  write data.
REQ-021 mem_be  out  4  byte enables; bit 3 = bits[31:24].
REQ-022 mem_ack  in  1  memory done, variable latency >= 1 cycle.
REQ-023 mem_rdata  in  32  read data, valid with mem_ack.
REQ-024 stall_if, stall_mem  out  1 each  if_req & ~if_valid, dm_req & ~dm_valid.

Function
REQ-025 FSM states: IDLE, BUSY_IF, BUSY_DM, RESP.
REQ-026 IDLE, dm_req only -> BUSY_DM; if_req only -> BUSY_IF; both -> BUSY_DM unless starve_cnt == STARVE_LIMIT, then BUSY_IF; neither -> IDLE.
REQ-027 On grant, latch address, write data, byte lane, we, byte, signextend and owner.
REQ-028 mem_req = 1 exactly in BUSY_IF/BUSY_DM; mem_* outputs driven from latched values, stable until mem_ack.
REQ-029 BUSY_x with mem_ack -> RESP, registering mem_rdata; without ack -> stay.
REQ-030 RESP: pulse x_valid for the latched owner for one cycle, then IDLE; requests are ignored in RESP.
REQ-031 Minimum latency: request seen in IDLE at cycle N, ack at N+1, valid at N+2.
REQ-032 Byte lanes are big-endian: lane = addr[1:0]; 0 -> mem_be 4'b1000, 3 -> 4'b0001.
REQ-033 Byte store: mem_wdata = {4{dm_wdata[7:0]}}, mem_be one-hot per lane.
REQ-034 Byte load: dm_rdata = selected byte, sign- or zero-extended per dm_signextend.
REQ-035 Word access: mem_be = 4'b1111; dm_rdata = mem_rdata.
REQ-036 Misaligned word access: performed aligned; dm_misalign = 1 with dm_valid.
REQ-037 Fetches always use word access; if_rdata = registered mem_rdata.
REQ-038 Stores: dm_rdata = 0.
REQ-039 starve_cnt: +1 on each DM grant while if_req = 1, saturating at STARVE_LIMIT; cleared on any IF grant.
REQ-040 mem_ack outside BUSY states is ignored.
REQ-041 if_rdata and dm_rdata hold their last value between pulses.

Reset
REQ-042 rst low asynchronously forces IDLE, starve_cnt = 0, all outputs 0 (including mid-transaction); no pulse on release.
REQ-043 A transaction aborted by reset is not replayed; requesters re-issue.

Structure
REQ-044 State encoding and byte-lane/be constants live in the shared mips_defines package.
REQ-045 One natural sub-module: mem_byte_lane (be generation, store replication, load extraction/extension), combinational.

Verification
REQ-046 if_req only, addr 0x100, ack after 1 cycle with rdata 0x2402000A -> mem_req at N+1, if_valid at N+2, if_rdata 0x2402000A.
REQ-047 Both requests in IDLE -> DM granted first, IF granted after RESP; stall_if high throughout.
REQ-048 Held dm_req plus if_req for 5 back-to-back grants, STARVE_LIMIT 4 -> grant order DM, DM, DM, DM, IF.
REQ-049 LB addr 0x203, mem_rdata 0x112233F0 -> mem_be 4'b0001, dm_rdata 0xFFFFFFF0; LBU -> 0x000000F0.
REQ-050 SB addr 0x201, wdata 0x000000AB -> mem_be 4'b0100, mem_wdata 0xABABABAB.
REQ-051 rst low during BUSY_DM with ack pending -> mem_req 0 same cycle, no dm_valid, IDLE after release.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the memory arbiter: FSM encoding, request owner and
// big-endian byte-lane enable constants.
package mips_defines;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY_IF = 2'd1,
    ST_BUSY_DM = 2'd2,
    ST_RESP    = 2'd3
  } arb_state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } owner_t;

  localparam logic [3:0] BE_WORD  = 4'b1111;
  localparam logic [3:0] BE_LANE0 = 4'b1000;

  // Lane 0 is the most significant byte (big-endian).
  function automatic logic [3:0] lane_be(input logic [1:0] lane);
    return BE_LANE0 >> lane;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Shared single-port memory bus: the arbiter drives requests, the memory
// answers with a variable-latency ack and read data.
interface mem_arbiter_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/mem_arbiter_byte_lane.sv
// Combinational byte-lane helper: store byte enables and data replication,
// load byte extraction with sign or zero extension.
module mem_byte_lane
  import mips_defines::*;
(
  input  logic        st_byte,
  input  logic [1:0]  st_lane,
  input  logic [31:0] st_wdata,
  output logic [3:0]  st_be,
  output logic [31:0] st_data,
  input  logic        ld_byte,
  input  logic [1:0]  ld_lane,
  input  logic        ld_sext,
  input  logic [31:0] ld_word,
  output logic [31:0] ld_data
);

  logic [7:0] ld_sel;

  always_comb begin
    st_be   = BE_WORD;
    st_data = st_wdata;
    if (st_byte) begin
      st_be   = lane_be(st_lane);
      st_data = {4{st_wdata[7:0]}};
    end

    case (ld_lane)
      2'd0:    ld_sel = ld_word[31:24];
      2'd1:    ld_sel = ld_word[23:16];
      2'd2:    ld_sel = ld_word[15:8];
      default: ld_sel = ld_word[7:0];
    endcase

    ld_data = ld_word;
    if (ld_byte)
      ld_data = ld_sext ? {{24{ld_sel[7]}}, ld_sel} : {24'h0, ld_sel};
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates instruction fetch and data accesses onto one memory port,
// data first with a starvation limit that eventually forces a fetch grant.
module mem_arbiter
  import mips_defines::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [31:0]   if_addr,
  output logic [31:0]   if_rdata,
  output logic          if_valid,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic          dm_byte,
  input  logic          dm_signextend,
  input  logic [31:0]   dm_addr,
  input  logic [31:0]   dm_wdata,
  output logic [31:0]   dm_rdata,
  output logic          dm_valid,
  output logic          dm_misalign,
  output logic          stall_if,
  output logic          stall_mem,
  mem_arbiter_if.master mem
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

  arb_state_t       state;
  owner_t           owner;
  logic [CNT_W-1:0] starve_cnt;
  logic [1:0]       lat_lane;
  logic             lat_byte, lat_sext, lat_we, lat_misalign;
  logic             grant_dm, grant_if;
  logic [3:0]       st_be;
  logic [31:0]      st_data, ld_data;

  assign grant_dm  = dm_req & (~if_req | (starve_cnt != STARVE_MAX));
  assign grant_if  = if_req & ~grant_dm;
  // Stalls are gated by reset so every output reads zero while rst is low.
  assign stall_if  = rst & if_req & ~if_valid;
  assign stall_mem = rst & dm_req & ~dm_valid;

  mem_byte_lane u_byte_lane (
    .st_byte  (dm_byte),
    .st_lane  (dm_addr[1:0]),
    .st_wdata (dm_wdata),
    .st_be    (st_be),
    .st_data  (st_data),
    .ld_byte  (lat_byte),
    .ld_lane  (lat_lane),
    .ld_sext  (lat_sext),
    .ld_word  (mem.mem_rdata),
    .ld_data  (ld_data)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= ST_IDLE;
      owner         <= OWN_IF;
      starve_cnt    <= '0;
      lat_lane      <= '0;
      lat_byte      <= 1'b0;
      lat_sext      <= 1'b0;
      lat_we        <= 1'b0;
      lat_misalign  <= 1'b0;
      if_rdata      <= '0;
      if_valid      <= 1'b0;
      dm_rdata      <= '0;
      dm_valid      <= 1'b0;
      dm_misalign   <= 1'b0;
      mem.mem_req   <= 1'b0;
      mem.mem_we    <= 1'b0;
      mem.mem_addr  <= '0;
      mem.mem_wdata <= '0;
      mem.mem_be    <= '0;
    end else begin
      if_valid    <= 1'b0;
      dm_valid    <= 1'b0;
      dm_misalign <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (grant_dm) begin
            state         <= ST_BUSY_DM;
            owner         <= OWN_DM;
            mem.mem_req   <= 1'b1;
            mem.mem_we    <= dm_we;
            mem.mem_addr  <= dm_addr & 32'hFFFF_FFFC;
            mem.mem_wdata <= st_data;
            mem.mem_be    <= st_be;
            lat_lane      <= dm_addr[1:0];
            lat_byte      <= dm_byte;
            lat_sext      <= dm_signextend;
            lat_we        <= dm_we;
            lat_misalign  <= ~dm_byte & (dm_addr[1:0] != 2'b00);
            if (if_req && starve_cnt != STARVE_MAX)
              starve_cnt <= starve_cnt + 1'b1;
          end else if (grant_if) begin
            state         <= ST_BUSY_IF;
            owner         <= OWN_IF;
            mem.mem_req   <= 1'b1;
            mem.mem_we    <= 1'b0;
            mem.mem_addr  <= if_addr & 32'hFFFF_FFFC;
            mem.mem_wdata <= '0;
            mem.mem_be    <= BE_WORD;
            lat_byte      <= 1'b0;
            lat_we        <= 1'b0;
            lat_misalign  <= 1'b0;
            starve_cnt    <= '0;
          end
        end
        ST_BUSY_IF, ST_BUSY_DM: begin
          if (mem.mem_ack) begin
            state       <= ST_RESP;
            mem.mem_req <= 1'b0;
            if (owner == OWN_IF) begin
              if_valid <= 1'b1;
              if_rdata <= mem.mem_rdata;
            end else begin
              dm_valid    <= 1'b1;
              dm_rdata    <= lat_we ? '0 : ld_data;
              dm_misalign <= lat_misalign;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one task per scenario, memory acks driven by hand.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic [31:0] if_rdata;
  logic        if_valid;
  logic        dm_req = 1'b0;
  logic        dm_we = 1'b0;
  logic        dm_byte = 1'b0;
  logic        dm_signextend = 1'b0;
  logic [31:0] dm_addr = '0;
  logic [31:0] dm_wdata = '0;
  logic [31:0] dm_rdata;
  logic        dm_valid;
  logic        dm_misalign;
  logic        stall_if;
  logic        stall_mem;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_arbiter_if bus ();

  mem_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .if_req        (if_req),
    .if_addr       (if_addr),
    .if_rdata      (if_rdata),
    .if_valid      (if_valid),
    .dm_req        (dm_req),
    .dm_we         (dm_we),
    .dm_byte       (dm_byte),
    .dm_signextend (dm_signextend),
    .dm_addr       (dm_addr),
    .dm_wdata      (dm_wdata),
    .dm_rdata      (dm_rdata),
    .dm_valid      (dm_valid),
    .dm_misalign   (dm_misalign),
    .stall_if      (stall_if),
    .stall_mem     (stall_mem),
    .mem           (bus)
  );

  task automatic test_reset;
    rst = 1'b0; if_req = 1'b1;
    @(negedge clk); @(negedge clk);
    checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL rst_mem_req: got %b want 0", bus.mem_req); end
    checks++; if (bus.mem_be !== 4'h0) begin errors++; $display("FAIL rst_mem_be: got %h want 0", bus.mem_be); end
    checks++; if (bus.mem_addr !== 32'h0) begin errors++; $display("FAIL rst_mem_addr: got %h want 0", bus.mem_addr); end
    checks++; if ({if_valid, dm_valid, dm_misalign} !== 3'b000) begin errors++; $display("FAIL rst_valids: got %b want 000", {if_valid, dm_valid, dm_misalign}); end
    checks++; if (stall_if !== 1'b0) begin errors++; $display("FAIL rst_stall_if: got %b want 0", stall_if); end
    checks++; if (if_rdata !== 32'h0 || dm_rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata: got %h/%h want 0/0", if_rdata, dm_rdata); end
    if_req = 1'b0; rst = 1'b1;
    @(negedge clk);
    checks++; if ({bus.mem_req, if_valid, dm_valid} !== 3'b000) begin errors++; $display("FAIL rst_release: got %b want 000", {bus.mem_req, if_valid, dm_valid}); end
  endtask

  task automatic test_fetch;
    if_req = 1'b1; if_addr = 32'h100;
    @(negedge clk);
    checks++; if (bus.mem_req !== 1'b1) begin errors++; $display("FAIL fetch_mem_req: got %b want 1", bus.mem_req); end
    checks++; if (bus.mem_addr !== 32'h100) begin errors++; $display("FAIL fetch_addr: got %h want 00000100", bus.mem_addr); end
    checks++; if ({bus.mem_we, bus.mem_be} !== 5'b0_1111) begin errors++; $display("FAIL fetch_we_be: got %b want 01111", {bus.mem_we, bus.mem_be}); end
    checks++; if (stall_if !== 1'b1) begin errors++; $display("FAIL fetch_stall: got %b want 1", stall_if); end
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'h2402000A;
    @(negedge clk);
    checks++; if (if_valid !== 1'b1) begin errors++; $display("FAIL fetch_valid: got %b want 1", if_valid); end
    checks++; if (if_rdata !== 32'h2402000A) begin errors++; $display("FAIL fetch_rdata: got %h want 2402000a", if_rdata); end
    checks++; if ({bus.mem_req, stall_if} !== 2'b00) begin errors++; $display("FAIL fetch_resp_req_stall: got %b want 00", {bus.mem_req, stall_if}); end
    bus.mem_ack = 1'b0; if_req = 1'b0;
    @(negedge clk);
    checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL fetch_pulse_len: got %b want 0", if_valid); end
    checks++; if (if_rdata !== 32'h2402000A) begin errors++; $display("FAIL fetch_hold: got %h want 2402000a", if_rdata); end
  endtask

  task automatic test_ack_ignored;
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'hDEAD0000;
    @(negedge clk); @(negedge clk);
    checks++; if ({bus.mem_req, if_valid, dm_valid} !== 3'b000) begin errors++; $display("FAIL idle_ack: got %b want 000", {bus.mem_req, if_valid, dm_valid}); end
    checks++; if (if_rdata !== 32'h2402000A) begin errors++; $display("FAIL idle_ack_rdata: got %h want 2402000a", if_rdata); end
    bus.mem_ack = 1'b0;
  endtask

  task automatic test_both_pending;
    dm_req = 1'b1; dm_we = 1'b0; dm_byte = 1'b0; dm_addr = 32'h300;
    if_req = 1'b1; if_addr = 32'h104;
    @(negedge clk);
    checks++; if (bus.mem_addr !== 32'h300 || bus.mem_req !== 1'b1) begin errors++; $display("FAIL both_first_grant: got req %b addr %h want 1 00000300", bus.mem_req, bus.mem_addr); end
    checks++; if (stall_if !== 1'b1) begin errors++; $display("FAIL both_stall_busy: got %b want 1", stall_if); end
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'hCAFEF00D;
    @(negedge clk);
    checks++; if ({dm_valid, if_valid} !== 2'b10) begin errors++; $display("FAIL both_dm_valid: got %b want 10", {dm_valid, if_valid}); end
    checks++; if (dm_rdata !== 32'hCAFEF00D) begin errors++; $display("FAIL both_dm_rdata: got %h want cafef00d", dm_rdata); end
    checks++; if (stall_if !== 1'b1) begin errors++; $display("FAIL both_stall_resp: got %b want 1", stall_if); end
    bus.mem_ack = 1'b0; dm_req = 1'b0;
    @(negedge clk);
    checks++; if ({bus.mem_req, stall_if} !== 2'b01) begin errors++; $display("FAIL both_idle: got %b want 01", {bus.mem_req, stall_if}); end
    @(negedge clk);
    checks++; if (bus.mem_addr !== 32'h104 || bus.mem_req !== 1'b1) begin errors++; $display("FAIL both_if_grant: got req %b addr %h want 1 00000104", bus.mem_req, bus.mem_addr); end
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'h11111111;
    @(negedge clk);
    checks++; if (if_valid !== 1'b1 || if_rdata !== 32'h11111111) begin errors++; $display("FAIL both_if_done: got %b %h want 1 11111111", if_valid, if_rdata); end
    bus.mem_ack = 1'b0; if_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_starvation;
    logic exp_dm [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    dm_req = 1'b1; dm_we = 1'b0; dm_byte = 1'b0; dm_addr = 32'h500;
    if_req = 1'b1; if_addr = 32'h600;
    for (int g = 0; g < 5; g++) begin
      int waited = 0;
      while (bus.mem_req !== 1'b1 && waited < 10) begin
        @(negedge clk);
        waited++;
      end
      checks++;
      if (bus.mem_req !== 1'b1) begin
        errors++; $display("FAIL starve_timeout: grant %0d got no mem_req want 1", g);
        break;
      end
      checks++; if (bus.mem_addr !== (exp_dm[g] ? 32'h500 : 32'h600)) begin errors++; $display("FAIL starve_order: grant %0d got addr %h want %h", g, bus.mem_addr, exp_dm[g] ? 32'h500 : 32'h600); end
      bus.mem_ack = 1'b1; bus.mem_rdata = 32'h1000 + g;
      @(negedge clk);
      bus.mem_ack = 1'b0;
      checks++; if ({dm_valid, if_valid} !== (exp_dm[g] ? 2'b10 : 2'b01)) begin errors++; $display("FAIL starve_valid: grant %0d got %b want %b", g, {dm_valid, if_valid}, exp_dm[g] ? 2'b10 : 2'b01); end
      if (g == 4) begin dm_req = 1'b0; if_req = 1'b0; end
    end
    bus.mem_ack = 1'b0; dm_req = 1'b0; if_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_byte_load;
    logic [31:0] exp_rd [2] = '{32'hFFFFFFF0, 32'h000000F0};
    for (int s = 0; s < 2; s++) begin
      dm_req = 1'b1; dm_we = 1'b0; dm_byte = 1'b1; dm_signextend = (s == 0); dm_addr = 32'h203;
      @(negedge clk);
      checks++; if (bus.mem_be !== 4'b0001 || bus.mem_addr !== 32'h200) begin errors++; $display("FAIL lb_be_addr: got %b %h want 0001 00000200", bus.mem_be, bus.mem_addr); end
      checks++; if (stall_mem !== 1'b1) begin errors++; $display("FAIL lb_stall: got %b want 1", stall_mem); end
      bus.mem_ack = 1'b1; bus.mem_rdata = 32'h112233F0;
      @(negedge clk);
      checks++; if (dm_valid !== 1'b1 || dm_rdata !== exp_rd[s]) begin errors++; $display("FAIL lb_rdata: sext %0d got %b %h want 1 %h", 1 - s, dm_valid, dm_rdata, exp_rd[s]); end
      checks++; if ({stall_mem, dm_misalign} !== 2'b00) begin errors++; $display("FAIL lb_stall_resp: got %b want 00", {stall_mem, dm_misalign}); end
      bus.mem_ack = 1'b0; dm_req = 1'b0;
      @(negedge clk);
      checks++; if (dm_valid !== 1'b0 || dm_rdata !== exp_rd[s]) begin errors++; $display("FAIL lb_hold: got %b %h want 0 %h", dm_valid, dm_rdata, exp_rd[s]); end
    end
    dm_byte = 1'b0; dm_signextend = 1'b0;
  endtask

  task automatic test_byte_store;
    dm_req = 1'b1; dm_we = 1'b1; dm_byte = 1'b1; dm_addr = 32'h201; dm_wdata = 32'h000000AB;
    @(negedge clk);
    checks++; if (bus.mem_be !== 4'b0100) begin errors++; $display("FAIL sb_be: got %b want 0100", bus.mem_be); end
    checks++; if (bus.mem_wdata !== 32'hABABABAB) begin errors++; $display("FAIL sb_wdata: got %h want abababab", bus.mem_wdata); end
    checks++; if (bus.mem_we !== 1'b1 || bus.mem_addr !== 32'h200) begin errors++; $display("FAIL sb_we_addr: got %b %h want 1 00000200", bus.mem_we, bus.mem_addr); end
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'h55555555;
    @(negedge clk);
    checks++; if (dm_valid !== 1'b1 || dm_rdata !== 32'h0) begin errors++; $display("FAIL sb_resp: got %b %h want 1 00000000", dm_valid, dm_rdata); end
    bus.mem_ack = 1'b0; dm_req = 1'b0; dm_we = 1'b0; dm_byte = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_misaligned_word;
    dm_req = 1'b1; dm_we = 1'b0; dm_byte = 1'b0; dm_addr = 32'h302;
    @(negedge clk);
    checks++; if (bus.mem_addr !== 32'h300 || bus.mem_be !== 4'b1111) begin errors++; $display("FAIL mis_addr_be: got %h %b want 00000300 1111", bus.mem_addr, bus.mem_be); end
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'h12345678;
    @(negedge clk);
    checks++; if ({dm_valid, dm_misalign} !== 2'b11) begin errors++; $display("FAIL mis_flag: got %b want 11", {dm_valid, dm_misalign}); end
    checks++; if (dm_rdata !== 32'h12345678) begin errors++; $display("FAIL mis_rdata: got %h want 12345678", dm_rdata); end
    bus.mem_ack = 1'b0; dm_req = 1'b0;
    @(negedge clk);
    checks++; if (dm_misalign !== 1'b0) begin errors++; $display("FAIL mis_clear: got %b want 0", dm_misalign); end
  endtask

  task automatic test_reset_mid;
    dm_req = 1'b1; dm_we = 1'b0; dm_byte = 1'b0; dm_addr = 32'h400;
    @(negedge clk);
    checks++; if (bus.mem_req !== 1'b1) begin errors++; $display("FAIL rmid_busy: got %b want 1", bus.mem_req); end
    #2 rst = 1'b0;
    #1;
    checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL rmid_async: got %b want 0", bus.mem_req); end
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'h87654321;
    @(negedge clk);
    checks++; if ({dm_valid, stall_mem} !== 2'b00) begin errors++; $display("FAIL rmid_no_valid: got %b want 00", {dm_valid, stall_mem}); end
    bus.mem_ack = 1'b0; dm_req = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    checks++; if ({bus.mem_req, dm_valid, if_valid} !== 3'b000) begin errors++; $display("FAIL rmid_release: got %b want 000", {bus.mem_req, dm_valid, if_valid}); end
    checks++; if (dm_rdata !== 32'h0) begin errors++; $display("FAIL rmid_rdata: got %h want 0", dm_rdata); end
    if_req = 1'b1; if_addr = 32'h700;
    @(negedge clk);
    checks++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h700) begin errors++; $display("FAIL rmid_idle_grant: got %b %h want 1 00000700", bus.mem_req, bus.mem_addr); end
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'h0BADF00D;
    @(negedge clk);
    checks++; if (if_valid !== 1'b1 || if_rdata !== 32'h0BADF00D) begin errors++; $display("FAIL rmid_refetch: got %b %h want 1 0badf00d", if_valid, if_rdata); end
    bus.mem_ack = 1'b0; if_req = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    bus.mem_ack = 1'b0;
    bus.mem_rdata = '0;
    test_reset();
    test_fetch();
    test_ack_ignored();
    test_both_pending();
    test_starvation();
    test_byte_load();
    test_byte_store();
    test_misaligned_word();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
